core_out_uart: RTL



---
 rtl/core_io_pkg.sv | 15 +
 rtl/core_out_uart_if.sv | 25 ++
 rtl/sync_fifo.sv | 55 +++++
 rtl/core_out_uart.sv | 122 ++++++++++++
 4 files changed

// File: rtl/core_io_pkg.sv
// Shared types and constants for the core character-output UART.
// Holds the UART FSM state enum and the 8N1 frame constants.
package core_io_pkg;

   typedef enum logic [1:0] {
      UART_IDLE,
      UART_START,
      UART_DATA,
      UART_STOP
   } uart_state_t;

   localparam int   UART_DATA_BITS  = 8;
   localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/core_out_uart_if.sv
// Bundle between the core's character output port and the UART.
// master: core side (drives in_en/in_data); slave: UART (drives status + tx).
interface core_out_uart_if #(
   parameter int FIFO_DEPTH_LOG2 = 4
);
   import core_io_pkg::*;

   logic                        in_en;
   logic [UART_DATA_BITS-1:0]   in_data;
   logic                        tx;
   logic                        busy;
   logic                        overflow;
   logic [FIFO_DEPTH_LOG2:0]    fifo_count;

   modport master (
      output in_en, in_data,
      input  tx, busy, overflow, fifo_count
   );

   modport slave (
      input  in_en, in_data,
      output tx, busy, overflow, fifo_count
   );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO; pushes are refused when full even if a pop shares the edge.
// Ports: clock, reset, push/push_data, pop/pop_data (show-ahead), count, full, empty.
module sync_fifo #(
   parameter int WIDTH      = 8,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  push,
   input  logic [WIDTH-1:0]      push_data,
   input  logic                  pop,
   output logic [WIDTH-1:0]      pop_data,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  full,
   output logic                  empty
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic                  do_push;
   logic                  do_pop;

   // full/empty come from the registered count, so a same-edge pop
   // never frees a slot for the incoming byte.
   assign full     = (count == FULL_CNT);
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/core_out_uart.sv
// Buffers core output bytes and sends them as 8N1 UART frames, LSB first.
// Ports: clock, reset, bus (slave: in_en/in_data in; tx/busy/overflow/fifo_count out).
module core_out_uart
   import core_io_pkg::*;
#(
   parameter int CLOCK_DIV       = 16,
   parameter int FIFO_DEPTH_LOG2 = 4
) (
   input  logic           clock,
   input  logic           reset,
   core_out_uart_if.slave bus
);

   localparam int BW = $clog2(CLOCK_DIV);
   localparam int IW = $clog2(UART_DATA_BITS);
   localparam logic [BW-1:0] RELOAD   = BW'(CLOCK_DIV - 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(UART_DATA_BITS - 1);

   uart_state_t               state_q, state_d;
   logic [UART_DATA_BITS-1:0] sr_q, sr_d;
   logic [BW-1:0]             bitcnt_q, bitcnt_d;
   logic [IW-1:0]             idx_q, idx_d;
   logic                      tx_q, tx_d;
   logic                      ovf_q;

   logic                      pop;
   logic [UART_DATA_BITS-1:0] head;
   logic [FIFO_DEPTH_LOG2:0]  count;
   logic                      full;
   logic                      empty;

   sync_fifo #(
      .WIDTH      (UART_DATA_BITS),
      .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (bus.in_en),
      .push_data (bus.in_data),
      .pop       (pop),
      .pop_data  (head),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= UART_IDLE;
         sr_q     <= '0;
         bitcnt_q <= '0;
         idx_q    <= '0;
         tx_q     <= UART_IDLE_LEVEL;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         sr_q     <= sr_d;
         bitcnt_q <= bitcnt_d;
         idx_q    <= idx_d;
         tx_q     <= tx_d;
         ovf_q    <= ovf_q | (bus.in_en & full);
      end
   end

   always_comb begin
      state_d  = state_q;
      sr_d     = sr_q;
      bitcnt_d = bitcnt_q;
      idx_d    = idx_q;
      tx_d     = tx_q;
      pop      = 1'b0;
      unique case (state_q)
         UART_IDLE: begin
            tx_d = UART_IDLE_LEVEL;
            if (!empty) begin
               pop      = 1'b1;
               sr_d     = head;
               tx_d     = ~UART_IDLE_LEVEL;
               bitcnt_d = RELOAD;
               state_d  = UART_START;
            end
         end
         UART_START: begin
            if (bitcnt_q == '0) begin
               tx_d     = sr_q[0];
               sr_d     = sr_q >> 1;
               idx_d    = '0;
               bitcnt_d = RELOAD;
               state_d  = UART_DATA;
            end else begin
               bitcnt_d = bitcnt_q - 1'b1;
            end
         end
         UART_DATA: begin
            if (bitcnt_q == '0) begin
               bitcnt_d = RELOAD;
               if (idx_q == LAST_IDX) begin
                  tx_d    = UART_IDLE_LEVEL;
                  state_d = UART_STOP;
               end else begin
                  tx_d  = sr_q[0];
                  sr_d  = sr_q >> 1;
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               bitcnt_d = bitcnt_q - 1'b1;
            end
         end
         UART_STOP: begin
            if (bitcnt_q == '0) state_d = UART_IDLE;
            else bitcnt_d = bitcnt_q - 1'b1;
         end
         default: state_d = UART_IDLE;
      endcase
   end

   assign bus.tx         = tx_q;
   assign bus.busy       = (state_q != UART_IDLE) || !empty;
   assign bus.overflow   = ovf_q;
   assign bus.fifo_count = count;

endmodule
